// File: rtl/nvme_cc_sequencer.sv
// nvme_cc_sequencer: CC.EN/CC.SHN controller sequencer driving CSTS and the queue-engine handshakes.
module nvme_cc_sequencer #(
    parameter int TICKS_PER_UNIT = 1000,
    parameter int RST_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cc_en,
    input  logic [1:0] cc_shn,
    input  logic [3:0] cap_to,
    input  logic       aq_valid,
    input  logic       init_done,
    input  logic       flush_done,
    output logic       init_req,
    output logic       flush_req,
    output logic       core_en,
    output logic       core_rst,
    output logic       csts_rdy,
    output logic [1:0] csts_shst,
    output logic       csts_cfs
);
    localparam int CW = 4 + $clog2(TICKS_PER_UNIT) + 1;
    typedef enum logic [2:0] {IDLE, INIT, READY, SHUTDOWN, SHDN_DONE, DISABLE, FATAL} state_t;
    state_t state;
    logic [CW-1:0] cnt, limit, lim_new;
    logic expired, busy;
    always_comb begin
        lim_new = CW'(cap_to == 4'd0 ? 4'd1 : cap_to) * CW'(TICKS_PER_UNIT);
        expired = (cnt + CW'(1)) == limit;
        busy = state != IDLE && state != DISABLE;
    end
    // The counter doubles as the core_rst pulse timer while in DISABLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            limit <= '0;
            init_req <= 1'b0;
            flush_req <= 1'b0;
            core_en <= 1'b0;
            core_rst <= 1'b0;
            csts_rdy <= 1'b0;
            csts_shst <= 2'b00;
            csts_cfs <= 1'b0;
        end else if (!cc_en && busy) begin
            state <= DISABLE;
            cnt <= '0;
            core_rst <= 1'b1;
            core_en <= 1'b0;
            init_req <= 1'b0;
            flush_req <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cc_en) begin
                    if (aq_valid) begin
                        state <= INIT;
                        cnt <= '0;
                        limit <= lim_new;
                        init_req <= 1'b1;
                    end else begin
                        state <= FATAL;
                        csts_cfs <= 1'b1;
                    end
                end
                INIT: if (init_done) begin
                    state <= READY;
                    init_req <= 1'b0;
                    csts_rdy <= 1'b1;
                    core_en <= 1'b1;
                end else if (expired) begin
                    state <= FATAL;
                    init_req <= 1'b0;
                    csts_cfs <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                READY: if (cc_shn != 2'b00) begin
                    state <= SHUTDOWN;
                    cnt <= '0;
                    limit <= lim_new;
                    core_en <= 1'b0;
                    flush_req <= 1'b1;
                    csts_shst <= 2'b01;
                end
                SHUTDOWN: if (flush_done) begin
                    state <= SHDN_DONE;
                    flush_req <= 1'b0;
                    csts_shst <= 2'b10;
                end else if (expired) begin
                    state <= FATAL;
                    flush_req <= 1'b0;
                    csts_cfs <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                DISABLE: if (cnt == CW'(RST_CYCLES - 1)) begin
                    state <= IDLE;
                    core_rst <= 1'b0;
                    csts_rdy <= 1'b0;
                    csts_shst <= 2'b00;
                    csts_cfs <= 1'b0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                SHDN_DONE, FATAL: state <= state;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nvme_cc_sequencer.sv
// tb_nvme_cc_sequencer: directed and randomized checks against an output-driven reference model.
module tb_nvme_cc_sequencer;
    localparam int TPU = 10;
    localparam int RSTC = 4;
    logic clk = 1'b0;
    logic reset, cc_en, aq_valid, init_done, flush_done;
    logic [1:0] cc_shn;
    logic [3:0] cap_to;
    logic init_req, flush_req, core_en, core_rst, csts_rdy, csts_cfs;
    logic [1:0] csts_shst;
    int checks = 0;
    int errors = 0;
    bit m_init_req, m_flush_req, m_core_en, m_core_rst, m_rdy, m_cfs;
    logic [1:0] m_shst;
    int rst_left, deadline, cyc;

    nvme_cc_sequencer #(.TICKS_PER_UNIT(TPU), .RST_CYCLES(RSTC)) dut (
        .clk(clk), .reset(reset), .cc_en(cc_en), .cc_shn(cc_shn), .cap_to(cap_to),
        .aq_valid(aq_valid), .init_done(init_done), .flush_done(flush_done),
        .init_req(init_req), .flush_req(flush_req), .core_en(core_en), .core_rst(core_rst),
        .csts_rdy(csts_rdy), .csts_shst(csts_shst), .csts_cfs(csts_cfs)
    );

    always #5 clk = ~clk;

    function logic [7:0] outv();
        return {init_req, flush_req, core_en, core_rst, csts_rdy, csts_shst, csts_cfs};
    endfunction

    function logic [7:0] model_v();
        return {m_init_req, m_flush_req, m_core_en, m_core_rst, m_rdy, m_shst, m_cfs};
    endfunction

    function int lim(input logic [3:0] c);
        return (c == 0 ? 1 : int'(c)) * TPU;
    endfunction

    task model_reset();
        {m_init_req, m_flush_req, m_core_en, m_core_rst, m_rdy, m_cfs} = '0;
        m_shst = 2'b00;
        rst_left = 0;
        deadline = 0;
    endtask

    // The model tracks what the host can see plus an absolute deadline, not a state register.
    task model_edge();
        cyc++;
        if (m_core_rst) begin
            rst_left--;
            if (rst_left == 0) begin
                m_core_rst = 0; m_rdy = 0; m_shst = 2'b00; m_cfs = 0;
            end
        end else if (!cc_en) begin
            if (m_init_req || m_rdy || m_cfs) begin
                m_core_rst = 1; rst_left = RSTC;
                m_init_req = 0; m_flush_req = 0; m_core_en = 0;
            end
        end else if (m_init_req) begin
            if (init_done) begin
                m_init_req = 0; m_rdy = 1; m_core_en = 1;
            end else if (cyc == deadline) begin
                m_init_req = 0; m_cfs = 1;
            end
        end else if (m_flush_req) begin
            if (flush_done) begin
                m_flush_req = 0; m_shst = 2'b10;
            end else if (cyc == deadline) begin
                m_flush_req = 0; m_cfs = 1;
            end
        end else if (m_core_en) begin
            if (cc_shn != 0) begin
                m_core_en = 0; m_flush_req = 1; m_shst = 2'b01; deadline = cyc + lim(cap_to);
            end
        end else if (!m_rdy && !m_cfs) begin
            if (aq_valid) begin
                m_init_req = 1; deadline = cyc + lim(cap_to);
            end else begin
                m_cfs = 1;
            end
        end
    endtask

    task step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task test_reset();
        reset = 1; cc_en = 0; cc_shn = 0; cap_to = 1; aq_valid = 1; init_done = 0; flush_done = 0;
        model_reset();
        cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outv() !== 8'h00) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", outv(), 8'h00); end
        @(negedge clk);
        reset = 0;
        repeat (2) begin
            step();
            checks++;
            if (outv() !== model_v()) begin errors++; $display("FAIL reset_idle got=%b exp=%b", outv(), model_v()); end
        end
    endtask

    task test_bringup();
        int hi;
        hi = 0;
        cap_to = 3; aq_valid = 1; cc_en = 1;
        repeat (5) begin
            step();
            hi += int'(init_req);
            checks++;
            if (outv() !== model_v()) begin errors++; $display("FAIL bringup_wait got=%b exp=%b", outv(), model_v()); end
        end
        init_done = 1;
        step();
        init_done = 0;
        hi += int'(init_req);
        checks++;
        if (hi !== 5) begin errors++; $display("FAIL bringup_init_req_cycles got=%0d exp=5", hi); end
        checks++;
        if ({init_req, csts_rdy, core_en, csts_cfs} !== 4'b0110) begin
            errors++; $display("FAIL bringup_ready got=%b exp=0110", {init_req, csts_rdy, core_en, csts_cfs});
        end
        cc_en = 0;
        repeat (RSTC + 1) begin
            step();
            checks++;
            if (outv() !== model_v()) begin errors++; $display("FAIL bringup_disable got=%b exp=%b", outv(), model_v()); end
        end
    endtask

    task test_init_timeout();
        int k, rc;
        k = 0; rc = 0;
        cap_to = 2; aq_valid = 1; cc_en = 1;
        step();
        for (int i = 0; i < 40 && !csts_cfs; i++) begin
            step();
            k++;
            checks++;
            if (outv() !== model_v()) begin errors++; $display("FAIL init_timeout_trace got=%b exp=%b", outv(), model_v()); end
        end
        checks++;
        if (k !== 20 || csts_cfs !== 1'b1) begin errors++; $display("FAIL init_timeout_cycles got=%0d cfs=%b exp=20 cfs=1", k, csts_cfs); end
        cc_en = 0;
        repeat (RSTC + 2) begin
            step();
            rc += int'(core_rst);
        end
        checks++;
        if (rc !== RSTC) begin errors++; $display("FAIL init_timeout_core_rst got=%0d exp=%0d", rc, RSTC); end
        checks++;
        if ({csts_cfs, csts_rdy} !== 2'b00) begin errors++; $display("FAIL init_timeout_cleared got=%b exp=00", {csts_cfs, csts_rdy}); end
    endtask

    task test_shutdown();
        int s1;
        s1 = 0;
        cap_to = 1; aq_valid = 1; cc_en = 1; cc_shn = 0;
        step();
        init_done = 1; step(); init_done = 0;
        cc_shn = 2'b01;
        repeat (3) begin
            step();
            s1 += int'(csts_shst == 2'b01);
            checks++;
            if (outv() !== model_v()) begin errors++; $display("FAIL shutdown_flush got=%b exp=%b", outv(), model_v()); end
        end
        flush_done = 1; step(); flush_done = 0;
        checks++;
        if (s1 !== 3 || csts_shst !== 2'b10 || csts_rdy !== 1'b1) begin
            errors++; $display("FAIL shutdown_done got=%0d/%b/%b exp=3/10/1", s1, csts_shst, csts_rdy);
        end
        cc_shn = 0;
        repeat (2) step();
        checks++;
        if ({csts_shst, csts_rdy, core_en} !== 4'b1010) begin errors++; $display("FAIL shutdown_hold got=%b exp=1010", {csts_shst, csts_rdy, core_en}); end
        cc_en = 0;
        repeat (RSTC + 1) begin
            step();
            checks++;
            if (outv() !== model_v()) begin errors++; $display("FAIL shutdown_disable got=%b exp=%b", outv(), model_v()); end
        end
        checks++;
        if (csts_shst !== 2'b00) begin errors++; $display("FAIL shutdown_shst_clear got=%b exp=00", csts_shst); end
    endtask

    task test_missing_aq();
        int seen;
        seen = 0;
        aq_valid = 0; cc_en = 1;
        step();
        checks++;
        if ({csts_cfs, init_req} !== 2'b10) begin errors++; $display("FAIL missing_aq_fatal got=%b exp=10", {csts_cfs, init_req}); end
        aq_valid = 1;
        repeat (5) begin
            step();
            seen += int'(init_req);
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL missing_aq_no_init got=%0d exp=0", seen); end
        cc_en = 0;
        repeat (RSTC + 1) step();
        checks++;
        if (outv() !== model_v()) begin errors++; $display("FAIL missing_aq_idle got=%b exp=%b", outv(), model_v()); end
    endtask

    task test_races();
        int k;
        cap_to = 1; aq_valid = 1; cc_en = 1;
        step();
        repeat (TPU - 1) step();
        init_done = 1; step(); init_done = 0;
        checks++;
        if ({csts_rdy, core_en, csts_cfs} !== 3'b110) begin errors++; $display("FAIL race_done_on_limit got=%b exp=110", {csts_rdy, core_en, csts_cfs}); end
        cc_shn = 2'b10; step(); cc_shn = 0;
        cc_en = 0; flush_done = 1; step(); flush_done = 0;
        checks++;
        if ({core_rst, csts_shst, csts_rdy} !== 4'b1011) begin errors++; $display("FAIL race_disable_vs_flush got=%b exp=1011", {core_rst, csts_shst, csts_rdy}); end
        cc_en = 1;
        repeat (RSTC) begin
            step();
            checks++;
            if (outv() !== model_v()) begin errors++; $display("FAIL race_en_during_disable got=%b exp=%b", outv(), model_v()); end
        end
        cap_to = 0;
        k = 0;
        step();
        for (int i = 0; i < 3 * TPU && !csts_cfs; i++) begin
            step();
            k++;
        end
        checks++;
        if (k !== lim(4'd0)) begin errors++; $display("FAIL race_cap_to_zero got=%0d exp=%0d", k, lim(4'd0)); end
        cc_en = 0;
        repeat (RSTC + 1) step();
    endtask

    task test_async_reset();
        cap_to = 2; aq_valid = 1; cc_en = 1;
        step();
        init_done = 1; step(); init_done = 0;
        cc_shn = 2'b01; step(); cc_shn = 0;
        #2 reset = 1;
        #2;
        model_reset();
        checks++;
        if (outv() !== 8'h00) begin errors++; $display("FAIL async_reset got=%b exp=%b", outv(), 8'h00); end
        #2 reset = 0;
        step();
        checks++;
        if (outv() !== model_v() || init_req !== 1'b1) begin errors++; $display("FAIL async_reset_reinit got=%b exp=%b", outv(), model_v()); end
        cc_en = 0;
        repeat (RSTC + 1) step();
    endtask

    task test_random();
        int bad;
        bad = 0;
        repeat (600) begin
            cc_en = $urandom_range(0, 19) != 0;
            cc_shn = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cap_to = 4'($urandom_range(0, 2));
            aq_valid = $urandom_range(0, 9) != 0;
            init_done = $urandom_range(0, 11) == 0;
            flush_done = $urandom_range(0, 11) == 0;
            step();
            checks++;
            if (outv() !== model_v()) begin
                errors++;
                if (bad < 10) $display("FAIL random cyc=%0d got=%b exp=%b", cyc, outv(), model_v());
                bad++;
            end
        end
        {init_done, flush_done, cc_shn} = '0;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_init_timeout();
        test_shutdown();
        test_missing_aq();
        test_races();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
